// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request kinds, FSM states,
// data-memory size and the legal-address check.
package lsu_pkg;

  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;

  localparam int MEM_WORDS  = 30;
  localparam int LSU_ADDR_W = 16;

  typedef enum logic {RUN, FENCE} state_t;

  // Legal when halfword-aligned and inside the data memory.
  function automatic logic addr_ok(input logic [LSU_ADDR_W-1:0] addr,
                                   input int words = MEM_WORDS);
    return !addr[0] && (32'(addr) < 32'(2 * words));
  endfunction

endpackage

// File: rtl/lsu_store_buffer_sb_fifo.sv
// Store-buffer storage: circular FIFO of (addr, data) with a parallel
// lookup that returns the youngest live entry matching a word address.
module sb_fifo #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            pushAddr,
  input  logic [DW-1:0]            pushData,
  output logic [AW-1:0]            headAddr,
  output logic [DW-1:0]            headData,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            lookupAddr,
  output logic                     lookupHit,
  output logic [DW-1:0]            lookupData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] addrQ;
  logic [DEPTH-1:0][DW-1:0] dataQ;
  logic [PW-1:0]            rdPtr, wrPtr;
  logic [DEPTH-1:0][PW-1:0] slot;
  logic [DEPTH-1:0]         match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrQ <= '0;
      dataQ <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addrQ[wrPtr] <= pushAddr;
        dataQ[wrPtr] <= pushData;
        wrPtr        <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign headAddr = addrQ[rdPtr];
  assign headData = dataQ[rdPtr];

  // slot[g] is the g-th oldest entry; only the first count slots are live.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot[g]  = rdPtr + PW'(g);
    assign match[g] = (CW'(g) < count) &&
                      (addrQ[slot[g]][AW-1:1] == lookupAddr[AW-1:1]);
  end

  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        lookupHit  = 1'b1;
        lookupData = dataQ[slot[i]];
      end
    end
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Load/store unit: buffered stores drained one per cycle, loads forwarded
// from the buffer or read from memory, with bounds checks and a fence.
module lsu_store_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = lsu_pkg::MEM_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  input  logic                   fence,
  output logic                   fence_done,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   mem_read,
  output logic [ADDR_W-1:0]      mem_read_addr,
  input  logic [DATA_W-1:0]      mem_read_data,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_write_addr,
  output logic [DATA_W-1:0]      mem_write_data
);

  import lsu_pkg::state_t;
  import lsu_pkg::RUN;
  import lsu_pkg::FENCE;
  import lsu_pkg::ST;
  import lsu_pkg::addr_ok;

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  logic              isStore, reqErr, accept, push, pop, ldOk, hit;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData, fwdData;

  assign isStore = (req_is_store == ST);
  assign reqErr  = !addr_ok(req_addr, MEM_WORDS);

  // Full test uses the registered count, so a popping-full buffer still refuses stores.
  assign req_ready = (state == RUN) && !fence &&
                     !(isStore && (sb_count == CW'(DEPTH)));
  assign accept    = req_valid && req_ready;
  assign push      = accept && isStore && !reqErr;
  assign ldOk      = accept && !isStore && !reqErr;
  assign pop       = (sb_count != '0);

  sb_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .pushAddr  (req_addr),
    .pushData  (req_wdata),
    .headAddr  (headAddr),
    .headData  (headData),
    .count     (sb_count),
    .lookupAddr(req_addr),
    .lookupHit (hit),
    .lookupData(fwdData)
  );

  assign mem_read       = ldOk && !hit;
  assign mem_read_addr  = mem_read ? req_addr : '0;
  assign mem_write      = pop;
  assign mem_write_addr = pop ? headAddr : '0;
  assign mem_write_data = pop ? headData : '0;

  assign fence_done = (state == FENCE) && (sb_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        RUN:     if (fence) state <= FENCE;
        FENCE:   if (sb_count == '0) state <= RUN;
        default: state <= RUN;
      endcase
      rsp_valid <= accept;
      rsp_err   <= accept && reqErr;
      // Hits never take mem_read_data: on a hit mem_read is low.
      rsp_rdata <= !ldOk ? '0 : (hit ? fwdData : mem_read_data);
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed scenarios plus random traffic checked
// against a queue-based reference model and a behavioural data memory.
module tb_lsu_store_buffer;

  localparam int DW = 16, AW = 16, DEPTH = 4, MW = 30;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_is_store = 1'b0, fence = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, fence_done, mem_read, mem_write;
  logic [DW-1:0] rsp_rdata, mem_read_data, mem_write_data;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [CW-1:0] sb_count;

  int nvec = 0, nfail = 0;

  always #5 clk = ~clk;

  lsu_store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fence(fence), .fence_done(fence_done), .sb_count(sb_count),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  // Data memory: re-initialised by reset, read combinationally, garbage when not read.
  function automatic logic [DW-1:0] init_word(int i);
    return (i == 0) ? 16'hABCD : 16'(16'h5A00 + i * 3);
  endfunction

  logic [DW-1:0] env_mem [MW];
  always @(posedge clk or negedge reset) begin
    if (!reset) for (int i = 0; i < MW; i++) env_mem[i] <= init_word(i);
    else if (mem_write && (mem_write_addr >> 1) < MW) env_mem[mem_write_addr >> 1] <= mem_write_data;
  end
  assign mem_read_data = (mem_read && (mem_read_addr >> 1) < MW) ? env_mem[mem_read_addr >> 1] : 16'hDEAD;

  // Reference model: pending stores in acceptance order, and the memory image they produce.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic [DW-1:0] ref_mem [MW];
  bit fencing;

  logic e_ready, e_mread, e_mwrite, e_fdone, e_rvalid, e_rerr;
  logic [AW-1:0] e_mraddr, e_mwaddr;
  logic [DW-1:0] e_mwdata, e_rdata;
  logic [CW-1:0] e_cnt;
  logic o_ready, o_mread, o_mwrite, o_fdone, o_rvalid, o_rerr;
  logic [AW-1:0] o_mraddr, o_mwaddr;
  logic [DW-1:0] o_mwdata, o_rdata;
  logic [CW-1:0] o_cnt;

  task automatic do_reset();
    reset = 1'b0; req_valid = 1'b0; fence = 1'b0;
    q.delete(); fencing = 0;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // One cycle: apply inputs, predict and sample pre-edge outputs, clock, predict and sample response.
  task automatic step(input bit v, input bit st, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit f);
    bit acc, bad, hit;
    logic [DW-1:0] fwd;
    req_valid = v; req_is_store = st; req_addr = a; req_wdata = d; fence = f;
    @(negedge clk);
    bad = a[0] || (int'(a) >= 2 * MW);
    e_ready = !fencing && !f && !(st && q.size() == DEPTH);
    acc = v && e_ready;
    hit = 0; fwd = '0;
    foreach (q[i]) if (q[i].a[AW-1:1] == a[AW-1:1]) begin hit = 1; fwd = q[i].d; end
    e_mwrite = q.size() != 0;
    e_mwaddr = e_mwrite ? q[0].a : '0;
    e_mwdata = e_mwrite ? q[0].d : '0;
    e_mread  = acc && !st && !bad && !hit;
    e_mraddr = e_mread ? a : '0;
    e_fdone  = fencing && q.size() == 0;
    e_cnt    = CW'(q.size());
    e_rvalid = acc;
    e_rerr   = acc && bad;
    e_rdata  = (acc && !st && !bad) ? (hit ? fwd : ref_mem[a >> 1]) : '0;
    o_ready = req_ready; o_mread = mem_read; o_mraddr = mem_read_addr;
    o_mwrite = mem_write; o_mwaddr = mem_write_addr; o_mwdata = mem_write_data;
    o_fdone = fence_done; o_cnt = sb_count;
    @(posedge clk);
    if (fencing && q.size() == 0) fencing = 0;
    else if (!fencing && f) fencing = 1;
    if (q.size() != 0) begin ref_mem[q[0].a >> 1] = q[0].d; void'(q.pop_front()); end
    if (acc && st && !bad) q.push_back('{a, d});
    #1;
    o_rvalid = rsp_valid; o_rerr = rsp_err; o_rdata = rsp_rdata;
    req_valid = 1'b0; fence = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; #2;
    nvec++;
    if ({rsp_valid, rsp_err, rsp_rdata, fence_done, sb_count, mem_write, mem_read} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h fd=%b cnt=%0d mw=%b mr=%b, want all 0",
               rsp_valid, rsp_err, rsp_rdata, fence_done, sb_count, mem_write, mem_read);
    end
    do_reset();
  endtask

  task automatic test_load_mem();
    step(1, 0, 16'h0000, '0, 0);
    nvec++;
    if (o_mread !== 1'b1 || o_mraddr !== 16'h0000) begin
      nfail++; $display("FAIL load_mem_read: mem_read=%b addr=%h, want 1/0000", o_mread, o_mraddr);
    end
    nvec++;
    if (o_rvalid !== 1'b1 || o_rerr !== 1'b0 || o_rdata !== 16'hABCD) begin
      nfail++; $display("FAIL load_mem_rsp: v=%b e=%b d=%h, want 1/0/abcd", o_rvalid, o_rerr, o_rdata);
    end
  endtask

  task automatic test_forward();
    step(1, 1, 16'h0004, 16'h1234, 0);
    nvec++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0000 || o_rerr !== 1'b0) begin
      nfail++; $display("FAIL store_rsp: v=%b e=%b d=%h, want 1/0/0000", o_rvalid, o_rerr, o_rdata);
    end
    step(1, 0, 16'h0004, '0, 0);
    nvec++;
    if (o_mread !== 1'b0 || o_rdata !== 16'h1234 || o_mwrite !== 1'b1) begin
      nfail++; $display("FAIL forward: mem_read=%b d=%h mw=%b, want 0/1234/1", o_mread, o_rdata, o_mwrite);
    end
    idle(2);
    nvec++;
    if (env_mem[2] !== 16'h1234) begin
      nfail++; $display("FAIL forward_mem: word2=%h, want 1234", env_mem[2]);
    end
  endtask

  task automatic test_youngest();
    step(1, 1, 16'h0002, 16'h1111, 0);
    step(1, 1, 16'h0002, 16'h2222, 0);
    step(1, 0, 16'h0002, '0, 0);
    nvec++;
    if (o_mread !== 1'b0 || o_rdata !== 16'h2222) begin
      nfail++; $display("FAIL youngest: mem_read=%b d=%h, want 0/2222", o_mread, o_rdata);
    end
    idle(3);
    nvec++;
    if (env_mem[1] !== 16'h2222) begin
      nfail++; $display("FAIL youngest_mem: word1=%h, want 2222", env_mem[1]);
    end
  endtask

  task automatic test_errors();
    logic [AW-1:0] addrs [2];
    addrs[0] = 16'h0003; addrs[1] = 16'h003C;
    for (int i = 0; i < 2; i++) begin
      step(1, i == 1, addrs[i], 16'h7777, 0);
      nvec++;
      if (o_rvalid !== 1'b1 || o_rerr !== 1'b1 || o_rdata !== 16'h0000 || o_mread !== 1'b0) begin
        nfail++; $display("FAIL err_%h: v=%b e=%b d=%h mr=%b, want 1/1/0000/0", addrs[i], o_rvalid, o_rerr, o_rdata, o_mread);
      end
      #2;
      nvec++;
      if (sb_count !== '0 || mem_write !== 1'b0) begin
        nfail++; $display("FAIL err_nopush_%h: cnt=%0d mw=%b, want 0/0", addrs[i], sb_count, mem_write);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] wr[$];
    bit ready_ok = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1, 1, AW'(2 * i), DW'(16'hC000 + i), 0);
      if (o_ready !== 1'b1) ready_ok = 0;
      if (o_mwrite === 1'b1) wr.push_back(o_mwaddr);
    end
    step(0, 0, '0, '0, 0);
    if (o_mwrite === 1'b1) wr.push_back(o_mwaddr);
    nvec++;
    if (!ready_ok) begin nfail++; $display("FAIL b2b_ready: req_ready dropped, want always 1"); end
    nvec++;
    if (wr.size() != DEPTH + 2) begin
      nfail++; $display("FAIL b2b_writes: %0d writes, want %0d", wr.size(), DEPTH + 2);
    end else begin
      foreach (wr[i]) if (wr[i] !== AW'(2 * i)) begin
        nfail++; $display("FAIL b2b_order[%0d]: addr=%h, want %h", i, wr[i], AW'(2 * i));
      end
    end
    idle(1);
  endtask

  task automatic test_fence();
    int pulses = 0;
    for (int i = 0; i < 3; i++) step(1, 1, AW'(8 + 2 * i), DW'(16'hF00 + i), 0);
    step(1, 0, 16'h0000, '0, 1);
    nvec++;
    if (o_ready !== 1'b0 || o_rvalid !== 1'b0) begin
      nfail++; $display("FAIL fence_priority: ready=%b rsp_valid=%b, want 0/0", o_ready, o_rvalid);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 0);
      if (o_fdone === 1'b1) begin
        pulses++;
        nvec++;
        if (o_cnt !== '0) begin nfail++; $display("FAIL fence_done_cnt: cnt=%0d, want 0", o_cnt); end
      end
    end
    nvec++;
    if (pulses != 1) begin nfail++; $display("FAIL fence_pulses: %0d pulses, want 1", pulses); end
    step(0, 0, '0, '0, 1);
    step(0, 0, '0, '0, 0);
    nvec++;
    if (o_fdone !== 1'b1) begin nfail++; $display("FAIL fence_empty: fence_done=%b, want 1", o_fdone); end
    step(1, 0, 16'h0000, '0, 0);
    nvec++;
    if (o_ready !== 1'b1 || o_fdone !== 1'b0) begin
      nfail++; $display("FAIL fence_exit: ready=%b fence_done=%b, want 1/0", o_ready, o_fdone);
    end
  endtask

  task automatic test_reset_mid_fence();
    step(1, 1, 16'h0010, 16'h5555, 0);
    step(0, 0, '0, '0, 1);
    #2 reset = 1'b0;
    #1;
    nvec++;
    if (sb_count !== '0 || fence_done !== 1'b0 || rsp_valid !== 1'b0) begin
      nfail++; $display("FAIL reset_mid_fence: cnt=%0d fence_done=%b rsp_valid=%b, want 0/0/0", sb_count, fence_done, rsp_valid);
    end
    do_reset();
    step(1, 0, 16'h0010, '0, 0);
    nvec++;
    if (o_ready !== 1'b1 || o_fdone !== 1'b0 || o_rdata !== init_word(8)) begin
      nfail++; $display("FAIL after_reset_run: ready=%b fd=%b d=%h, want 1/0/%h", o_ready, o_fdone, o_rdata, init_word(8));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int r = $urandom_range(0, 99);
      logic [AW-1:0] a = (r < 8) ? AW'($urandom_range(0, 16'hFFFF)) : AW'(2 * $urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, DW'($urandom), $urandom_range(0, 19) == 0);
      nvec++;
      if ({o_ready, o_mread, o_mraddr, o_mwrite, o_mwaddr, o_mwdata, o_fdone, o_cnt} !==
          {e_ready, e_mread, e_mraddr, e_mwrite, e_mwaddr, e_mwdata, e_fdone, e_cnt}) begin
        nfail++;
        $display("FAIL rand_pre cyc %0d: got rdy=%b mr=%b/%h mw=%b/%h/%h fd=%b cnt=%0d want rdy=%b mr=%b/%h mw=%b/%h/%h fd=%b cnt=%0d",
                 c, o_ready, o_mread, o_mraddr, o_mwrite, o_mwaddr, o_mwdata, o_fdone, o_cnt,
                 e_ready, e_mread, e_mraddr, e_mwrite, e_mwaddr, e_mwdata, e_fdone, e_cnt);
      end
      nvec++;
      if ({o_rvalid, o_rerr, o_rdata} !== {e_rvalid, e_rerr, e_rdata}) begin
        nfail++;
        $display("FAIL rand_rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 c, o_rvalid, o_rerr, o_rdata, e_rvalid, e_rerr, e_rdata);
      end
    end
    idle(DEPTH + 2);
  endtask

  task automatic test_memory_image();
    for (int i = 0; i < MW; i++) begin
      nvec++;
      if (env_mem[i] !== ref_mem[i]) begin
        nfail++; $display("FAIL mem_image[%0d]: got %h want %h", i, env_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mem();
    test_forward();
    test_youngest();
    test_errors();
    test_back_to_back();
    test_fence();
    test_reset_mid_fence();
    test_random();
    test_memory_image();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Load/store unit between the MEM-stage pipeline register and the 16-bit data memory (30 words, byte addresses, word index = addr/2).
- Stores are queued in a DEPTH-entry FIFO and drained to memory at one write per cycle, so stores never stall the pipeline while the buffer has room.
- Loads read memory combinationally, or are forwarded from the buffer, and return a registered response one cycle after acceptance.
- Also performs alignment and bounds checking, and provides a fence for draining the buffer.

Parameters:
- DATA_W, 16, data width.
- ADDR_W, 16, byte-address width.
- DEPTH, 4, store-buffer entries (power of 2, at least 2).
- MEM_WORDS, 30, words in data memory; legal byte addresses are 0 to 2*MEM_WORDS-2, even only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  DATA_W  load data; 0 for stores and for errors.
- rsp_err  out  1  misaligned or out-of-range request.
- fence  in  1  pulse: drain the buffer before further requests.
- fence_done  out  1  one-cycle pulse when the fence completes.
- sb_count  out  $clog2(DEPTH)+1  current buffer occupancy.
- mem_read  out  1  to memory MemRead.
- mem_read_addr  out  ADDR_W  to memory readAddress.
- mem_read_data  in  DATA_W  from memory readData.
- mem_write  out  1  to memory MemWrite.
- mem_write_addr  out  ADDR_W  to memory writeAddress.
- mem_write_data  out  DATA_W  to memory writeData.

Behaviour:
- Reset (async, active-low):
  - Buffer emptied, pointers cleared, sb_count=0, FSM goes to RUN.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, fence_done=0.
  - Queued stores are discarded; memory re-initialises on the same reset.
  - A reset mid-drain or mid-fence leaves no residual state.
- FSM states:
  - RUN: req_ready=1 except for a store when the buffer is full. Load readiness is unaffected by buffer fullness.
  - RUN to FENCE: when fence=1. The fence has priority; a request in that same cycle is not accepted (req_ready=0).
  - FENCE: req_ready=0; draining continues.
  - FENCE to RUN: on the cycle sb_count==0, with fence_done=1 that cycle.
  - A fence with the buffer already empty gives fence_done exactly one cycle after the fence pulse.
- Error check at acceptance: error when req_addr[0]==1 or req_addr >= 2*MEM_WORDS.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - No buffer entry is created and no memory access is made.
- Store accepted in cycle T:
  - Entry (addr, data) is pushed at the T edge.
  - rsp_valid=1 with rsp_rdata=0 in T+1.
  - Earliest memory write is in cycle T+1.
- Drain, every cycle the buffer is non-empty:
  - mem_write=1, mem_write_addr=head.addr, mem_write_data=head.data.
  - Head is popped at the clock edge.
  - Otherwise mem_write=0 and the write address/data are 0.
- Simultaneous push and pop: both happen and sb_count is unchanged. The full test uses the registered count, so a full buffer does not accept a store even in a cycle it pops.
- Load accepted in cycle T:
  - Match on word address (addr[ADDR_W-1:1]) against all valid entries, including the head being written this cycle.
  - On a hit, the youngest matching entry's data is returned and mem_read=0.
  - On a miss, mem_read=1 and mem_read_addr=req_addr in cycle T, and mem_read_data is captured at the T edge.
  - rsp_valid=1 with rsp_rdata in T+1.
- When no load is missing, mem_read=0 and mem_read_addr=0. rsp_rdata must never capture mem_read_data while mem_read=0.
- Pointer wrap-around: indices run modulo DEPTH. The full/empty distinction uses sb_count.
- Ordering: stores reach memory in acceptance order.

Decomposition:
- Shared package lsu_pkg holds:
  - the request-kind constants LD and ST;
  - the state enum RUN/FENCE;
  - MEM_WORDS;
  - the function addr_ok(addr), covering alignment and bounds.
- One sub-module, sb_fifo: the DEPTH-entry storage with push/pop, count, and a parallel youngest-match lookup port.
- The FSM, error logic and memory muxing stay in the top level.

Test Plan:
1. Load 0x0000 after reset -> rsp_valid next cycle, rsp_rdata=0xABCD, rsp_err=0, mem_read=1 during the request cycle.
2. Store 0x1234 to 0x0004, then load 0x0004 the next cycle -> load is forwarded (mem_read=0), rsp_rdata=0x1234. Memory word 2 is 0x1234 afterwards.
3. Stores to 0x0002 (0x1111) then 0x0002 (0x2222), followed immediately by a load of 0x0002 -> 0x2222 (youngest match). Memory ends at 0x2222.
4. Load 0x0003 and store to 0x003C -> each gives rsp_err=1, rsp_rdata=0, no mem_read/mem_write pulses, sb_count unchanged.
5. Fill: DEPTH+2 back-to-back stores with the drain active -> req_ready never drops; writes appear in order with addresses 0,2,4,...
6. Three stores, then fence -> req_ready=0 until empty, fence_done one pulse when sb_count reaches 0. A reset asserted mid-fence gives sb_count=0, RUN state and no fence_done.
